ifetch_queue: RTL

- Parametrised instruction prefetch queue between the instruction RAM port and the IF/ID register.
- Supersedes the single-entry, single-outstanding iram fetch path with a DEPTH-entry queue and up to MAX_OUTST pipelined requests.
- Handles redirects (flush, exception, branch) by dropping stale responses.
- Flags misaligned fetch addresses as fetch exceptions.

---
 rtl/ifq_pkg.sv | 20 ++
 rtl/ifq_checker.sv | 29 ++
 rtl/ifq_fifo.sv | 57 +++++
 rtl/ifetch_queue.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Holds the reset vector, the queue entry layout and the counter-width helper.
package ifq_pkg;

    localparam logic [31:0] RESET_VEC = 32'hBFC0_0000;

    // Address-error-on-load exception code reported to CP0 for bad fetches.
    localparam logic [4:0] EXC_ADEL = 5'h04;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        excp;
    } ifq_entry_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ifq_checker.sv
// Protocol and structural assertions for the prefetch queue.
module ifq_checker #(
    parameter int CNT_W = 2,
    parameter int OCC_W = 3,
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    input logic             mem_req,
    input logic [1:0]       mem_addr_lo,
    input logic             mem_rvalid,
    input logic [CNT_W-1:0] outst,
    input logic             push,
    input logic [OCC_W-1:0] occ
);

    a_rvalid_owed: assert property (@(posedge clk) disable iff (!rst)
        !(mem_rvalid && (outst == '0)))
        else $error("ifq: response with no outstanding request");

    a_req_aligned: assert property (@(posedge clk) disable iff (!rst)
        mem_req |-> (mem_addr_lo == 2'b00))
        else $error("ifq: unaligned request address");

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        push |-> (int'(occ) < DEPTH))
        else $error("ifq: push into a full queue");

endmodule

// File: rtl/ifq_fifo.sv
// Synchronous DEPTH-entry FIFO with wrap-around pointers and an extra MSB,
// exposing occupancy and a synchronous clear.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int W     = 65,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic             empty,
    output logic [PTR_W:0]   occ
);

    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1'b1);

    logic [W-1:0]   mem_r [DEPTH];
    logic [PTR_W:0] wptr_r;
    logic [PTR_W:0] rptr_r;
    logic           full_s;
    logic           push_s;
    logic           pop_s;

    // Status and guarded push/pop strobes.
    always_comb begin
        empty  = (wptr_r == rptr_r);
        full_s = (wptr_r[PTR_W] != rptr_r[PTR_W]) &&
                 (wptr_r[PTR_W-1:0] == rptr_r[PTR_W-1:0]);
        occ    = wptr_r - rptr_r;
        push_s = push & ~full_s & ~clr;
        pop_s  = pop & ~empty & ~clr;
        rdata  = mem_r[rptr_r[PTR_W-1:0]];
    end

    // Pointer update; clear and reset both empty the queue.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (push_s) wptr_r <= wptr_r + PTR_ONE;
            if (pop_s)  rptr_r <= rptr_r + PTR_ONE;
        end
    end

    // Entry storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wptr_r[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: pipelined iram requests with credit control,
// redirect-time discard of stale responses and misaligned-PC exceptions.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int               ADDR_W    = 32,
    parameter int               DATA_W    = 32,
    parameter int               DEPTH     = 4,
    parameter int               MAX_OUTST = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VEC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [ADDR_W-1:0] deq_pc,
    output logic [DATA_W-1:0] deq_inst,
    output logic              deq_excp
);

    localparam int CNT_W   = cnt_width(MAX_OUTST);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = ADDR_W + DATA_W + 1;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(32'd4);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1'b1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
        logic              excp;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] pc_tail_r;
    logic [CNT_W-1:0]  outst_r;
    logic [CNT_W-1:0]  discard_r;
    logic              halted_r;

    logic [CNT_W-1:0]  live_s;
    logic [CNT_W-1:0]  outst_nxt_s;
    logic              credit_s;
    logic              grant_s;
    logic              rsp_s;
    logic              drop_s;
    logic              push_rsp_s;
    logic              misal_s;
    logic              push_s;
    logic              pop_s;
    entry_t            wentry_s;
    entry_t            head_s;
    logic              empty_s;
    logic [PTR_W:0]    occ_s;

    // Request credit, response classification and queue write selection.
    always_comb begin
        live_s     = outst_r - discard_r;
        credit_s   = ((int'(occ_s) + int'(live_s)) < DEPTH) && (int'(outst_r) < MAX_OUTST);
        mem_req    = rst & ~redirect & ~halted_r & (fetch_pc_r[1:0] == 2'b00) & credit_s;
        mem_addr   = fetch_pc_r;
        grant_s    = mem_req & mem_gnt;
        // Responses with nothing owed (e.g. after a core reset) are ignored.
        rsp_s      = mem_rvalid & (outst_r != '0);
        drop_s     = rsp_s & (discard_r != '0);
        push_rsp_s = rsp_s & ~drop_s & ~redirect;
        misal_s    = rst & ~redirect & ~halted_r & (fetch_pc_r[1:0] != 2'b00) &
                     (live_s == '0) & (int'(occ_s) < DEPTH);
        push_s     = push_rsp_s | misal_s;
        deq_valid  = rst & ~empty_s;
        pop_s      = deq_valid & deq_ready & ~redirect;
        deq_pc     = head_s.pc;
        deq_inst   = head_s.inst;
        deq_excp   = head_s.excp;
        if (misal_s) begin
            wentry_s = '{pc: fetch_pc_r, inst: '0, excp: 1'b1};
        end else begin
            wentry_s = '{pc: pc_tail_r, inst: mem_rdata, excp: 1'b0};
        end
        case ({grant_s, rsp_s})
            2'b10:   outst_nxt_s = outst_r + CNT_ONE;
            2'b01:   outst_nxt_s = outst_r - CNT_ONE;
            default: outst_nxt_s = outst_r;
        endcase
    end

    // Fetch PC, tail PC, in-flight/discard counters and halt flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_r <= RESET_PC;
            pc_tail_r  <= RESET_PC;
            outst_r    <= '0;
            discard_r  <= '0;
            halted_r   <= 1'b0;
        end else if (redirect) begin
            // Everything still owed after this edge belongs to the old stream.
            fetch_pc_r <= redirect_pc;
            pc_tail_r  <= redirect_pc;
            halted_r   <= 1'b0;
            outst_r    <= outst_nxt_s;
            discard_r  <= outst_nxt_s;
        end else begin
            outst_r <= outst_nxt_s;
            if (grant_s)    fetch_pc_r <= fetch_pc_r + PC_STEP;
            if (push_rsp_s) pc_tail_r  <= pc_tail_r + PC_STEP;
            if (drop_s)     discard_r  <= discard_r - CNT_ONE;
            if (misal_s)    halted_r   <= 1'b1;
        end
    end

    ifq_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (redirect),
        .push  (push_s),
        .wdata (wentry_s),
        .pop   (pop_s),
        .rdata (head_s),
        .empty (empty_s),
        .occ   (occ_s)
    );

    ifq_checker #(
        .CNT_W (CNT_W),
        .OCC_W (PTR_W + 1),
        .DEPTH (DEPTH)
    ) u_checker (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr_lo (mem_addr[1:0]),
        .mem_rvalid  (mem_rvalid),
        .outst       (outst_r),
        .push        (push_s),
        .occ         (occ_s)
    );

endmodule
